// File: rtl/text_pkg.sv
// text_pkg: shared constants and state type for the text fetch sequencer.
// Cell timing phases, blink bit positions and the line FSM encoding.
package text_pkg;

   localparam int         CELL_W           = 9;
   localparam logic [3:0] LOAD_PHASE       = 4'd8;
   localparam logic [3:0] FONT_PHASE       = 4'd3;
   localparam logic [3:0] CODE_PHASE       = 4'd1;
   localparam int         BLINK_BIT        = 4;
   localparam int         CURSOR_BLINK_BIT = 3;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

endpackage

// File: rtl/cell_counter.sv
// cell_counter: phase/col/scan/row/row_base counters for text fetch.
// In: clk, reset, frame_start, line_start, run. Out: start, line_done, phase, col, scan, row_base.
module cell_counter
   import text_pkg::*;
#(
   parameter int COLS    = 80,
   parameter int ROWS    = 25,
   parameter int CHAR_H  = 16,
   parameter int VRAM_AW = 11,
   parameter int COL_W   = $clog2(COLS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_start,
   input  logic               line_start,
   input  logic               run,
   output logic               start,
   output logic               line_done,
   output logic [3:0]         phase,
   output logic [COL_W-1:0]   col,
   output logic [3:0]         scan,
   output logic [VRAM_AW-1:0] row_base
);

   localparam int ROW_W = $clog2(ROWS + 1);
   localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]   ROW_END   = ROW_W'(ROWS);
   localparam logic [3:0]         SCAN_LAST = 4'(CHAR_H - 1);
   localparam logic [VRAM_AW-1:0] ROW_STEP  = VRAM_AW'(COLS);

   logic [ROW_W-1:0] row;
   logic [ROW_W-1:0] row_next;
   logic             line_end;
   logic             scan_wrap;

   // An abort ends the line exactly like a completed one.
   assign line_done = run && phase == LOAD_PHASE && col == COL_LAST;
   assign line_end  = line_done || (run && line_start);
   assign scan_wrap = line_end && scan == SCAN_LAST;

   always_comb begin
      row_next = row;
      if (frame_start)
         row_next = '0;
      else if (scan_wrap)
         row_next = row + 1'b1;
   end

   // Start is judged against the row the new line would fetch.
   assign start = line_start && row_next != ROW_END;

   always_ff @(posedge clk) begin
      if (reset) begin
         phase    <= '0;
         col      <= '0;
         scan     <= '0;
         row      <= '0;
         row_base <= '0;
      end else begin
         row <= row_next;
         if (start) begin
            phase <= '0;
            col   <= '0;
         end else if (run) begin
            if (phase == LOAD_PHASE) begin
               phase <= '0;
               col   <= (col == COL_LAST) ? '0 : col + 1'b1;
            end else begin
               phase <= phase + 1'b1;
            end
         end
         if (frame_start) begin
            scan     <= '0;
            row_base <= '0;
         end else if (line_end) begin
            scan <= scan_wrap ? '0 : scan + 1'b1;
            if (scan_wrap)
               row_base <= row_base + ROW_STEP;
         end
      end
   end

endmodule

// File: rtl/text_fetch_sequencer.sv
// text_fetch_sequencer: VRAM -> font ROM fetch per 9-dot cell, load strobe, blink.
// Ports: CRTC pulses in, VRAM/font read ports, cursor config, pixel-gen outputs. Macro TEXT_CURSOR_EN.
module text_fetch_sequencer
   import text_pkg::*;
#(
   parameter int COLS    = 80,
   parameter int ROWS    = 25,
   parameter int CHAR_H  = 16,
   parameter int VRAM_AW = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               line_start,
   input  logic               frame_start,
   output logic               vram_rd,
   output logic [VRAM_AW-1:0] vram_addr,
   input  logic [15:0]        vram_data,
   output logic [11:0]        font_addr,
   input  logic [7:0]         font_q,
   input  logic [VRAM_AW-1:0] cursor_addr,
   input  logic [3:0]         cursor_start,
   input  logic [3:0]         cursor_end,
   input  logic               cursor_en,
   output logic               load,
   output logic [7:0]         attribute_data,
   output logic [7:0]         font_data,
   output logic [2:0]         char_msbs,
   output logic               cursor_active,
   output logic               blink_state
);

   localparam int COL_W = $clog2(COLS);
   localparam logic [3:0] PRE_LOAD = LOAD_PHASE - 4'd1;

   state_t               state;
   state_t               state_nxt;
   logic                 run;
   logic                 start;
   logic                 line_done;
   logic [3:0]           phase;
   logic [COL_W-1:0]     col;
   logic [3:0]           scan;
   logic [VRAM_AW-1:0]   row_base;
   logic [VRAM_AW-1:0]   cell_addr;
   logic                 fetch;
   logic [7:0]           code_r;
   logic [7:0]           attr_r;
   logic [7:0]           font_stage;
   logic [4:0]           frame_cnt;
   logic                 cursor_hit;

   cell_counter #(
      .COLS    (COLS),
      .ROWS    (ROWS),
      .CHAR_H  (CHAR_H),
      .VRAM_AW (VRAM_AW)
   ) u_cnt (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .line_start  (line_start),
      .run         (run),
      .start       (start),
      .line_done   (line_done),
      .phase       (phase),
      .col         (col),
      .scan        (scan),
      .row_base    (row_base)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // A rejected line_start during RUN still kills the line.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:
            if (start)
               state_nxt = RUN;
         RUN:
            if (start)
               state_nxt = RUN;
            else if (line_done || line_start)
               state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   assign run       = state == RUN;
   assign cell_addr = row_base + VRAM_AW'(col);
   assign fetch     = run && phase == 4'd0;
   assign vram_rd   = fetch;
   assign vram_addr = fetch ? cell_addr : '0;
   assign font_addr = {code_r, scan};

`ifdef TEXT_CURSOR_EN
   assign cursor_hit = cursor_en
                    && frame_cnt[CURSOR_BLINK_BIT]
                    && cell_addr == cursor_addr
                    && cursor_start <= scan
                    && scan <= cursor_end;
`else
   logic unused_cursor;
   assign unused_cursor = ^{cursor_addr, cursor_start, cursor_end, cursor_en};
   assign cursor_hit    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         frame_cnt <= '0;
      else if (frame_start)
         frame_cnt <= frame_cnt + 5'd1;
   end

   assign blink_state = frame_cnt[BLINK_BIT];

   // Outputs are registered on the edge into LOAD_PHASE so load and data align.
   always_ff @(posedge clk) begin
      if (reset) begin
         code_r         <= '0;
         attr_r         <= '0;
         font_stage     <= '0;
         load           <= 1'b0;
         attribute_data <= '0;
         font_data      <= '0;
         char_msbs      <= '0;
         cursor_active  <= 1'b0;
      end else begin
         load <= 1'b0;
         if (run && phase == CODE_PHASE)
            {attr_r, code_r} <= vram_data;
         if (run && phase == FONT_PHASE)
            font_stage <= font_q;
         if (run && phase == PRE_LOAD && !line_start) begin
            load           <= 1'b1;
            attribute_data <= attr_r;
            font_data      <= font_stage;
            char_msbs      <= code_r[7:5];
            cursor_active  <= cursor_hit;
         end
      end
   end

endmodule

// File: tb/tb_text_fetch_sequencer.sv
// tb_text_fetch_sequencer: randomized scoreboard bench for text_fetch_sequencer.
// Expected fetches/loads come from a line-level model of the text screen.
module tb_text_fetch_sequencer;

   localparam int COLS   = 80;
   localparam int ROWS   = 25;
   localparam int CHAR_H = 16;
   localparam int AW     = 11;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          line_start = 1'b0;
   logic          frame_start = 1'b0;
   logic          vram_rd;
   logic [AW-1:0] vram_addr;
   logic [15:0]   vram_data = '0;
   logic [11:0]   font_addr;
   logic [7:0]    font_q = '0;
   logic [AW-1:0] cursor_addr = '0;
   logic [3:0]    cursor_start = '0;
   logic [3:0]    cursor_end = '0;
   logic          cursor_en = 1'b0;
   logic          load;
   logic [7:0]    attribute_data;
   logic [7:0]    font_data;
   logic [2:0]    char_msbs;
   logic          cursor_active;
   logic          blink_state;

   text_fetch_sequencer #(
      .COLS(COLS), .ROWS(ROWS), .CHAR_H(CHAR_H), .VRAM_AW(AW)
   ) dut (
      .clk(clk), .reset(reset),
      .line_start(line_start), .frame_start(frame_start),
      .vram_rd(vram_rd), .vram_addr(vram_addr), .vram_data(vram_data),
      .font_addr(font_addr), .font_q(font_q),
      .cursor_addr(cursor_addr), .cursor_start(cursor_start),
      .cursor_end(cursor_end), .cursor_en(cursor_en),
      .load(load), .attribute_data(attribute_data), .font_data(font_data),
      .char_msbs(char_msbs), .cursor_active(cursor_active),
      .blink_state(blink_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] vram [1<<AW];
   logic [7:0]  rom  [4096];

   always @(posedge clk) begin
      if (vram_rd) vram_data <= vram[vram_addr];
      font_q <= rom[font_addr];
   end

   typedef struct {
      int         t;
      logic [7:0] attr;
      logic [7:0] font;
      logic [2:0] msbs;
      logic       cur;
   } ld_t;

   typedef struct {
      int            t;
      logic [AW-1:0] addr;
   } rd_t;

   ld_t ldq[$];
   rd_t rdq[$];
   int  checks = 0;
   int  errors = 0;
   int  exp_loads = 0;
   int  seen_loads = 0;
   int  m_frame = 0;
   int  m_scan = 0;
   int  m_row = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      ld_t e;
      rd_t r;
      if (load) begin
         seen_loads++;
         if (ldq.size() == 0) begin
            chk("load_unexpected", 1, 0);
         end else begin
            e = ldq.pop_front();
            chk("load_cycle", cyc, e.t);
            chk("attribute_data", attribute_data, e.attr);
            chk("font_data", font_data, e.font);
            chk("char_msbs", char_msbs, e.msbs);
            chk("cursor_active", cursor_active, e.cur);
         end
      end
      if (vram_rd) begin
         if (rdq.size() == 0) begin
            chk("vram_rd_unexpected", 1, 0);
         end else begin
            r = rdq.pop_front();
            chk("vram_rd_cycle", cyc, r.t);
            chk("vram_addr", vram_addr, r.addr);
         end
      end
   end

   task automatic drop_future(input int t0);
      while (ldq.size() > 0 && ldq[$].t >= t0) begin
         void'(ldq.pop_back());
         exp_loads--;
      end
      while (rdq.size() > 0 && rdq[$].t >= t0)
         void'(rdq.pop_back());
   endtask

   // Called at a negedge; returns at the negedge inside cycle 0 of the line.
   task automatic issue(input bit fs, input bit ls);
      int            now;
      logic [AW-1:0] a;
      logic [15:0]   w;
      logic          cur;
      ld_t           e;
      rd_t           r;
      now = cyc;
      if (ls) drop_future(now + 1);
      if (fs) begin
         m_frame++;
         m_scan = 0;
         m_row = 0;
      end
      if (ls && m_row != ROWS) begin
         for (int c = 0; c < COLS; c++) begin
            a = AW'((m_row * COLS + c) % (1 << AW));
            w = vram[a];
            cur = 1'b0;
`ifdef TEXT_CURSOR_EN
            cur = cursor_en && m_frame[3] && a == cursor_addr
                  && int'(cursor_start) <= m_scan && m_scan <= int'(cursor_end);
`endif
            r.t = now + 1 + 9 * c;
            r.addr = a;
            rdq.push_back(r);
            e.t = now + 9 + 9 * c;
            e.attr = w[15:8];
            e.font = rom[{w[7:0], m_scan[3:0]}];
            e.msbs = w[7:5];
            e.cur = cur;
            ldq.push_back(e);
            exp_loads++;
         end
         m_scan++;
         if (m_scan == CHAR_H) begin
            m_scan = 0;
            m_row++;
         end
      end
      frame_start = fs;
      line_start = ls;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      line_start = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((ldq.size() > 0 || rdq.size() > 0) && n < 1500) begin
         @(negedge clk);
         n++;
      end
      chk("line_timeout", n < 1500, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_zero();
      chk("rst_load", load, 0);
      chk("rst_vram_rd", vram_rd, 0);
      chk("rst_vram_addr", vram_addr, 0);
      chk("rst_font_addr", font_addr, 0);
      chk("rst_attr", attribute_data, 0);
      chk("rst_font", font_data, 0);
      chk("rst_msbs", char_msbs, 0);
      chk("rst_cursor", cursor_active, 0);
      chk("rst_blink", blink_state, 0);
   endtask

   task automatic frame_only();
      issue(1'b1, 1'b0);
      chk("blink_state", blink_state, m_frame[4]);
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) vram[i] = 16'($urandom);
      for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
      vram[0] = 16'h1FC4;
      rom[12'hC40] = 8'hAA;
      cursor_en = 1'b1;
      cursor_addr = AW'(5);
      cursor_start = 4'd14;
      cursor_end = 4'd15;

      repeat (3) @(negedge clk);
      check_zero();
      reset = 1'b0;
      @(negedge clk);

      frame_only();
      for (int l = 0; l < 17; l++) begin
         issue(1'b0, 1'b1);
         wait_done();
      end

      for (int f = 0; f < 39; f++) frame_only();

      issue(1'b1, 1'b1);
      for (int l = 0; l < 13; l++) begin
         repeat (11) @(negedge clk);
         issue(1'b0, 1'b1);
      end
      wait_done();
      issue(1'b0, 1'b1);
      wait_done();

      while (m_row < ROWS) begin
         repeat (11) @(negedge clk);
         issue(1'b0, 1'b1);
      end
      wait_done();
      for (int l = 0; l < 3; l++) begin
         issue(1'b0, 1'b1);
         repeat (20) @(negedge clk);
      end
      repeat (700) @(negedge clk);

      issue(1'b1, 1'b1);
      repeat (99) @(negedge clk);
      issue(1'b0, 1'b1);
      wait_done();

      for (int l = 0; l < 30; l++) begin
         repeat ($urandom_range(760, 5)) @(negedge clk);
         cursor_en = 1'($urandom_range(1, 0));
         cursor_addr = AW'(m_row * COLS + int'($urandom_range(COLS - 1, 0)));
         cursor_start = 4'($urandom_range(15, 0));
         cursor_end = 4'($urandom_range(15, 0));
         issue(1'($urandom_range(3, 0) == 0), 1'b1);
      end
      wait_done();

      issue(1'b0, 1'b1);
      repeat (49) @(negedge clk);
      drop_future(cyc + 1);
      m_frame = 0;
      m_scan = 0;
      m_row = 0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_zero();
      reset = 1'b0;
      repeat (800) @(negedge clk);

      chk("load_count", seen_loads, exp_loads);
      chk("ldq_empty", ldq.size(), 0);
      chk("rdq_empty", rdq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
